// File: rtl/spi_rx_axis_packer.sv
// Tags SPI RX words with frame index and sequence number, buffers them in a
// show-ahead FIFO and presents them as an AXI4-Stream master with packet tlast.
module spi_rx_axis_packer #(
   parameter int unsigned FIFO_DEPTH       = 16,
   parameter int unsigned PACKET_LEN       = 256,
   parameter int unsigned BIT_PER_TRANSFER = 18
) (
   input  logic                          i_Clk,
   input  logic                          i_Rst_L,
   input  logic                          i_RX_DV,
   input  logic [BIT_PER_TRANSFER-1:0]   i_RX_Byte,
   input  logic [2:0]                    i_RX_Count,
   input  logic                          i_Clear,
   output logic [31:0]                   m_axis_tdata,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   output logic                          m_axis_tlast,
   output logic                          o_Overflow,
   output logic [15:0]                   o_Drop_Count,
   output logic [$clog2(FIFO_DEPTH):0]   o_Fill
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned FW = AW + 1;
   localparam int unsigned PW = (PACKET_LEN > 1) ? $clog2(PACKET_LEN) : 1;

   typedef struct packed {
      logic                        last;
      logic [7:0]                  seq;
      logic [2:0]                  pad;
      logic [2:0]                  idx;
      logic [BIT_PER_TRANSFER-1:0] word;
   } beat_t;

   beat_t          mem_q [FIFO_DEPTH];
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [FW-1:0]  fill_q, fill_d;
   logic [7:0]     seq_q, seq_d;
   logic [PW-1:0]  pkt_q, pkt_d;
   logic           ovf_q, ovf_d;
   logic [15:0]    drop_q, drop_d;

   logic  full, not_empty, push, drop, pop, pkt_wrap;
   beat_t wr_beat, head;

   // Full means drop even when a pop happens in the same cycle; clear wins over everything.
   always_comb begin
      full      = (fill_q == FW'(FIFO_DEPTH));
      not_empty = (fill_q != '0);
      push      = i_RX_DV && !full && !i_Clear;
      drop      = i_RX_DV && full && !i_Clear;
      pop       = not_empty && m_axis_tready && !i_Clear;
      pkt_wrap  = (pkt_q == PW'(PACKET_LEN - 1));
      wr_beat   = '{last: pkt_wrap, seq: seq_q, pad: 3'b000, idx: i_RX_Count, word: i_RX_Byte};
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      fill_d   = fill_q;
      seq_d    = seq_q;
      pkt_d    = pkt_q;
      ovf_d    = ovf_q;
      drop_d   = drop_q;
      if (i_Clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         fill_d   = '0;
         seq_d    = '0;
         pkt_d    = '0;
         ovf_d    = 1'b0;
         drop_d   = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            seq_d    = seq_q + 8'd1;
            pkt_d    = pkt_wrap ? '0 : pkt_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         fill_d = fill_q + FW'(push) - FW'(pop);
         if (drop) begin
            ovf_d = 1'b1;
            if (drop_q != 16'hFFFF) begin
               drop_d = drop_q + 16'd1;
            end
         end
      end
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fill_q   <= '0;
         seq_q    <= '0;
         pkt_q    <= '0;
         ovf_q    <= 1'b0;
         drop_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         fill_q   <= fill_d;
         seq_q    <= seq_d;
         pkt_q    <= pkt_d;
         ovf_q    <= ovf_d;
         drop_q   <= drop_d;
      end
   end

   // Storage is data-only; the empty-gate below keeps stale entries invisible.
   always_ff @(posedge i_Clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= wr_beat;
      end
   end

   always_comb begin
      head          = mem_q[rd_ptr_q];
      m_axis_tvalid = not_empty;
      m_axis_tdata  = not_empty ? 32'(head[31:0]) : 32'd0;
      m_axis_tlast  = not_empty && head.last;
      o_Overflow    = ovf_q;
      o_Drop_Count  = drop_q;
      o_Fill        = fill_q;
   end

endmodule

// File: doc/spi_rx_axis_packer.md
# spi_rx_axis_packer

Downstream consumer of the 18-bit SPI master's RX word stream. Each `i_RX_DV` pulse from the master is captured along with its in-frame index and tagged with an 8-bit sequence number. The tagged word is buffered in a small FIFO and presented as a 32-bit AXI4-Stream master to the DMA. `tlast` is asserted every `PACKET_LEN` accepted words. Words that arrive while the FIFO is full are dropped and counted.

## Interface
- `FIFO_DEPTH`, 16: buffer entries; power of 2, ≥2.
- `PACKET_LEN`, 256: accepted words per AXIS packet; ≥1.
- `BIT_PER_TRANSFER`, 18: RX word width; fixed at 18 for this block.
- `i_Clk` in 1: system clock; single clock domain.
- `i_Rst_L` in 1: reset, asynchronous, active-low.
- `i_RX_DV` in 1: one-cycle pulse; RX word valid.
- `i_RX_Byte` in 18: RX word from the SPI master.
- `i_RX_Count` in 3: index of the word within its CS frame.
- `i_Clear` in 1: synchronous soft clear.
- `m_axis_tdata` out 32: packed beat.
- `m_axis_tvalid` out 1: beat valid.
- `m_axis_tready` in 1: DMA ready.
- `m_axis_tlast` out 1: last beat of a packet.
- `o_Overflow` out 1: sticky; set when at least one word was dropped.
- `o_Drop_Count` out 16: number of dropped words; saturates at 0xFFFF.
- `o_Fill` out clog2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation
- Beat format:
  - [17:0] `i_RX_Byte`
  - [20:18] `i_RX_Count`
  - [23:21] 0
  - [31:24] `seq`
  - `tlast` is stored in the FIFO alongside the beat.
- `seq` is an 8-bit counter. It increments on each accepted word and wraps 0xFF→0x00. Dropped words do not consume a sequence number.
- `pkt_cnt` ranges 0..PACKET_LEN-1 and increments on each accepted word.
  - The accepted word with `pkt_cnt == PACKET_LEN-1` is stored with `tlast=1`, and `pkt_cnt` returns to 0.
  - With `PACKET_LEN=1`, every beat carries `tlast`.
- Accept/drop decision:
  - A write is accepted iff `i_RX_DV=1` and `o_Fill < FIFO_DEPTH` at that edge.
  - A pop in the same cycle does not free space for the write. Full means drop, even if a pop occurs.
  - On a drop: set `o_Overflow`, and increment `o_Drop_Count` unless it is already 0xFFFF.
- The FIFO is show-ahead: `m_axis_tdata` and `m_axis_tlast` always reflect the head entry, and `m_axis_tvalid = (o_Fill != 0)`.
- A pop occurs when `tvalid && tready`.
  - Simultaneous push and pop on a non-full FIFO leaves `o_Fill` unchanged.
  - Read and write pointers wrap modulo `FIFO_DEPTH`.
- `i_Clear=1` at an edge:
  - Empties the FIFO and zeroes `seq`, `pkt_cnt`, `o_Overflow` and `o_Drop_Count`.
  - Clear has priority: a concurrent `i_RX_DV` word is discarded and not counted as dropped.
  - A concurrent handshake is void; nothing is considered transferred.
- Reset (`i_Rst_L=0`) takes effect immediately without a clock edge:
  - `tvalid`=0, `tlast`=0, `tdata`=0.
  - `o_Overflow`=0, `o_Drop_Count`=0, `o_Fill`=0.
  - `seq`=0 and `pkt_cnt`=0; pointers are cleared.
- AXIS rule: while `tvalid && !tready`, `tdata` and `tlast` are held stable. The head entry is never overwritten.

## Timing
- Latency: a word sampled at edge N with the FIFO empty produces `tvalid=1` after edge N, with correct `tdata`.
- Throughput: 1 word/cycle in and 1 beat/cycle out. The SPI source delivers far slower than this.
- Counter updates:
  - `o_Fill` updates at the same edge as the push/pop.
  - `o_Overflow` and `o_Drop_Count` update at the edge where the drop occurs.
- There is no combinational path from `i_RX_DV` to any output. `tready` affects only next-edge state.

## Test plan
1. **Single word to empty FIFO.** Reset, `tready=1`, one DV pulse with `i_RX_Byte=0x3AAAA` and `i_RX_Count=1`.
   - Required: one cycle later, `tvalid=1`, `tdata=0x0007AAAA`, `tlast=0`.
   - The beat transfers in that cycle, and `o_Fill` returns to 0.
2. **Backpressure, full FIFO and drop.** `tready=0`, then 17 DV pulses carrying words 0..16.
   - Required: `o_Fill=16`, `o_Overflow=1`, `o_Drop_Count=1`.
   - Then `tready=1`: exactly 16 beats with `seq` 0..15 and data 0..15. Word 16 never appears.
3. **Packet boundaries.** `PACKET_LEN=4`, 8 words with `tready` toggling every cycle.
   - Required: `tlast=1` only on beats 4 and 8.
   - `tdata` and `tlast` stay stable across every stalled cycle.
4. **Sequence wrap.** 257 accepted words with `tready=1`.
   - Required: beat 256 carries `seq=0xFF`, beat 257 carries `seq=0x00`.
   - With default `PACKET_LEN`, `tlast` is set on beat 256 only.
5. **Reset mid-operation.** FIFO holds 5 words and `tready=0`; pulse `i_Rst_L` low between clock edges.
   - Required: `tvalid`, `o_Fill` and `tdata` go to 0 immediately.
   - After release, the first new word has `seq=0`.
6. **Clear collides with data.** `o_Overflow=1` and 3 words are buffered; assert `i_Clear` and `i_RX_DV` in the same cycle.
   - Required: `o_Fill=0`, `o_Overflow=0`, `o_Drop_Count=0`.
   - The next DV word appears with `seq=0`.
